eth_tx_tick_scheduler: RTL and testbench
========================================

Name: eth_tx_tick_scheduler

Overview:
Periodic transmit scheduler for the Ethernet datapath. Consumes the 10 us and 1 s tick pulses from the free-running time counter, and keeps one programmable interval per channel (heartbeat, status report, ARP refresh, etc.). It arbitrates expired channels round-robin onto a single req/ack/done handshake toward the UDP/MAC transmit path. A per-grant timeout guards against a stalled MAC.

Parameters:
NUM_CH, 4, number of scheduled channels (2..8)
INTV_W, 16, width of each interval field, in ticks
CH_W, 2, width of tx_ch; ceil(log2(NUM_CH))
TO_10US, 100, grant timeout in 10 us ticks (default 1 ms)

Ports:
clk  in  1  system clock (50 MHz)
rstn  in  1  reset, asynchronous, active-low
tick_10us  in  1  one-cycle pulse every 10 us, from the time counter
tick_1s  in  1  one-cycle pulse every 1 s, from the time counter
cfg_en  in  NUM_CH  per-channel enable
cfg_unit  in  NUM_CH  per-channel tick select: 0 = tick_10us, 1 = tick_1s
cfg_intv  in  NUM_CH*INTV_W  per-channel interval; channel i occupies bits [i*INTV_W +: INTV_W]
tx_req  out  1  transmit request to the TX path
tx_ch  out  CH_W  channel being requested/served
tx_ack  in  1  TX path accepted the request
tx_done  in  1  one-cycle pulse: frame fully sent
busy  out  1  grant in progress (state != IDLE)
pend  out  NUM_CH  per-channel pending flags
ovf_flag  out  NUM_CH  sticky: expiry while already pending
ovf_clr  in  NUM_CH  per-bit clear of ovf_flag
err_timeout  out  1  one-cycle pulse on grant timeout

Behaviour:
- Reset: all outputs 0; counters 0; FSM IDLE; rr pointer = NUM_CH-1, so channel 0 wins first.
- Channel active = cfg_en[i] and cfg_intv[i] != 0. An interval of 0 means the channel never fires.
- Per-channel down-counter cnt[i]:
  - Loaded with cfg_intv[i] on the first cycle the channel is active (enable rising edge, or interval going nonzero).
  - On its selected tick: if cnt[i]==1, set pend[i] and reload cnt[i] with cfg_intv[i]; otherwise decrement cnt[i].
  - Interval N therefore fires every N ticks, with the first fire N ticks after enable.
  - cfg_intv changes while active take effect at the next reload.
- The unselected tick is ignored. Both ticks arriving in the same cycle is legal; each channel sees only its own.
- Expiry while pend[i]=1: pend stays 1 (requests coalesce) and ovf_flag[i] is set.
- ovf_clr and a set in the same cycle: set wins.
- Channel becoming inactive: cnt[i] is cleared next cycle and pend[i] cleared. A grant already in flight for that channel completes normally.
- Latency: tick in cycle T -> pend at T+1 -> tx_req high at T+2 if the FSM is IDLE.
- FSM:
  - IDLE: if any pend bit is set, select the first pending channel searching from rr+1 upward with wrap. Register it into tx_ch, clear the timeout counter, go to REQ.
  - REQ: tx_req=1; tx_ch held stable. On tx_ack, clear pend[tx_ch] and go to WAIT. If tx_done is also asserted that cycle, go straight to IDLE. rr is updated to tx_ch on leaving REQ by ack.
  - WAIT: tx_req=0. On tx_done, go to IDLE. tx_ack in WAIT is ignored.
- tx_done outside WAIT (and outside REQ with ack) is ignored.
- A re-expiry of tx_ch in the same cycle as the ack clear: the set wins, pend stays 1, and no ovf is flagged.
- Timeout: a counter increments on tick_10us while in REQ or WAIT. On reaching TO_10US:
  - err_timeout pulses for one cycle; pend[tx_ch] is cleared; rr = tx_ch; FSM goes to IDLE.
  - If ack or done arrives in the same cycle, it takes precedence and no timeout is raised.
- An unsolicited tx_ack in IDLE is ignored.
- tx_ch is held at its last value in IDLE.
- An asynchronous reset mid-grant drops tx_req immediately and reinitialises everything.

Test Plan:
- Ch0 en, unit=0, intv=3; ack 2 cycles after req, done 10 cycles later -> tx_req rises 2 cycles after every 3rd tick_10us; tx_ch=0; pend0 clears on ack.
- Ch0..3 all intv=1 on tick_1s, ack/done immediate -> grants in order 0,1,2,3; after the next tick, 0,1,2,3 again; no ovf.
- Ch1 intv=1 (10 us), tx_done withheld for 25 us -> ovf_flag[1]=1 and pend1 stays 1; after done, exactly one extra grant of ch1. Then ovf_clr[1] -> ovf_flag[1]=0.
- Req with no ack, TO_10US=100 -> err_timeout pulses after 100 tick_10us; busy=0; pend cleared. A following expiry on another channel is granted next.
- Ch2 intv=0 with cfg_en=1 -> never pends. Then cfg_en[2] dropped while ch2 is in WAIT -> grant finishes on done; pend2 stays 0.
- rstn asserted while in REQ -> tx_req=0, pend=0, ovf_flag=0 asynchronously. After release with ch0 intv=2 on 10 us ticks, the first req follows the 2nd tick.

Source files
------------

// File: rtl/eth_tx_tick_scheduler_if.sv
// ---------------------------------------------------------------------------
// eth_tx_tick_scheduler_if
// Request/acknowledge/done handshake between the periodic transmit scheduler
// and the UDP/MAC transmit path.
//
// Signals:
//   tx_req   scheduler -> TX path   request a frame for channel tx_ch
//   tx_ch    scheduler -> TX path   channel being requested/served
//   tx_ack   TX path -> scheduler   request accepted
//   tx_done  TX path -> scheduler   one-cycle pulse, frame fully sent
//
// Modports:
//   master   scheduler side
//   slave    TX path side
// ---------------------------------------------------------------------------
interface eth_tx_tick_scheduler_if #(
    parameter int CH_W = 2
) ();
    logic            tx_req;
    logic [CH_W-1:0] tx_ch;
    logic            tx_ack;
    logic            tx_done;

    modport master (
        output tx_req,
        output tx_ch,
        input  tx_ack,
        input  tx_done
    );

    modport slave (
        input  tx_req,
        input  tx_ch,
        output tx_ack,
        output tx_done
    );
endinterface

// File: rtl/eth_tx_tick_scheduler.sv
// ---------------------------------------------------------------------------
// eth_tx_tick_scheduler
// Periodic transmit scheduler. Each channel owns a programmable interval
// counted in 10 us or 1 s ticks. Expired channels are marked pending and
// granted round-robin onto one req/ack/done handshake. A per-grant timeout,
// counted in 10 us ticks, recovers from a stalled TX path.
//
// Ports:
//   clk          system clock
//   rstn         asynchronous active-low reset
//   tick_10us    one-cycle pulse every 10 us
//   tick_1s      one-cycle pulse every 1 s
//   cfg_en       per-channel enable
//   cfg_unit     per-channel tick select (0 = 10 us, 1 = 1 s)
//   cfg_intv     per-channel interval, channel i at [i*INTV_W +: INTV_W]
//   tx           handshake toward the TX path (tx_req/tx_ch/tx_ack/tx_done)
//   busy         a grant is in progress
//   pend         per-channel pending flags
//   ovf_flag     sticky: channel expired while already pending
//   ovf_clr      per-bit clear of ovf_flag
//   err_timeout  one-cycle pulse when a grant times out
// ---------------------------------------------------------------------------
module eth_tx_tick_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int INTV_W  = 16,
    parameter int CH_W    = 2,
    parameter int TO_10US = 100
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       tick_10us,
    input  logic                       tick_1s,
    input  logic [NUM_CH-1:0]          cfg_en,
    input  logic [NUM_CH-1:0]          cfg_unit,
    input  logic [NUM_CH*INTV_W-1:0]   cfg_intv,
    eth_tx_tick_scheduler_if.master    tx,
    output logic                       busy,
    output logic [NUM_CH-1:0]          pend,
    output logic [NUM_CH-1:0]          ovf_flag,
    input  logic [NUM_CH-1:0]          ovf_clr,
    output logic                       err_timeout
);

    localparam int TO_W = $clog2(TO_10US + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CH_W-1:0]   tx_ch_reg;
    logic [CH_W-1:0]   rr_reg;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic              err_timeout_reg;
    logic [NUM_CH-1:0] pend_reg, pend_next;
    logic [NUM_CH-1:0] ovf_reg, ovf_next;

    logic              grant_ack;
    logic              grant_done_wait;
    logic              to_hit;
    logic              sel_found;
    logic [CH_W-1:0]   sel_ch;
    logic [CH_W-1:0]   scan_idx;

    assign grant_ack       = (state_reg == REQ)  && tx.tx_ack;
    assign grant_done_wait = (state_reg == WAIT) && tx.tx_done;

    // The counter saturates at TO_10US, so if ack wins exactly on the expiry
    // tick the timeout still fires on the next tick while waiting for done.
    assign to_hit = (state_reg != IDLE) && tick_10us &&
                    (to_cnt_reg >= TO_W'(TO_10US - 1)) &&
                    !grant_ack && !grant_done_wait;

    // ------------------------------------------------------------------
    // Per-channel interval counters and pending/overflow flags
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [INTV_W-1:0] intv;
            logic [INTV_W-1:0] cnt_reg, cnt_next;
            logic              active, active_reg;
            logic              tick_sel;
            logic              expire;
            logic              grant_clr;

            assign intv     = cfg_intv[gi*INTV_W +: INTV_W];
            assign active   = cfg_en[gi] && (intv != '0);
            assign tick_sel = cfg_unit[gi] ? tick_1s : tick_10us;
            // No expiry on the load cycle: the first fire is N ticks later.
            assign expire   = active && active_reg && tick_sel &&
                              (cnt_reg == INTV_W'(1));
            assign grant_clr = (grant_ack || to_hit) &&
                               (tx_ch_reg == CH_W'(gi));

            always_comb begin
                cnt_next = cnt_reg;
                if (!active) begin
                    cnt_next = '0;
                end else if (!active_reg) begin
                    cnt_next = intv;
                end else if (tick_sel) begin
                    cnt_next = (cnt_reg == INTV_W'(1)) ? intv
                                                       : cnt_reg - INTV_W'(1);
                end
            end

            // Expiry beats the grant clear; an expiry that lands on the
            // clearing cycle is a fresh request, not an overflow.
            assign pend_next[gi] = !active   ? 1'b0 :
                                   expire    ? 1'b1 :
                                   grant_clr ? 1'b0 : pend_reg[gi];

            assign ovf_next[gi]  = (expire && pend_reg[gi] && !grant_clr) ? 1'b1 :
                                   ovf_clr[gi] ? 1'b0 : ovf_reg[gi];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_reg    <= '0;
                    active_reg <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    active_reg <= active;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: first pending channel after rr, with wrap.
    // Scanning from the far end lets the nearest hit overwrite the others.
    // ------------------------------------------------------------------
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        scan_idx  = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            scan_idx = CH_W'((int'(rr_reg) + k) % NUM_CH);
            if (pend_reg[scan_idx]) begin
                sel_found = 1'b1;
                sel_ch    = scan_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (tx.tx_ack) begin
                    state_next = tx.tx_done ? IDLE : WAIT;
                end else if (to_hit) begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (tx.tx_done || to_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx.tx_req = (state_reg == REQ);
        busy      = (state_reg != IDLE);
    end

    // ------------------------------------------------------------------
    // Grant bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        to_cnt_next = to_cnt_reg;
        if (state_reg == IDLE) begin
            to_cnt_next = '0;
        end else if (tick_10us && (to_cnt_reg < TO_W'(TO_10US))) begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_ch_reg       <= '0;
            rr_reg          <= CH_W'(NUM_CH - 1);
            to_cnt_reg      <= '0;
            err_timeout_reg <= 1'b0;
            pend_reg        <= '0;
            ovf_reg         <= '0;
        end else begin
            to_cnt_reg      <= to_cnt_next;
            err_timeout_reg <= to_hit;
            pend_reg        <= pend_next;
            ovf_reg         <= ovf_next;
            if ((state_reg == IDLE) && sel_found) begin
                tx_ch_reg <= sel_ch;
            end
            if (grant_ack || to_hit) begin
                rr_reg <= tx_ch_reg;
            end
        end
    end

    assign tx.tx_ch    = tx_ch_reg;
    assign pend        = pend_reg;
    assign ovf_flag    = ovf_reg;
    assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_eth_tx_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_tick_scheduler
// Self-checking bench for eth_tx_tick_scheduler. Expected grant channels are
// queued when the expiring tick is driven; a TX-path responder pops and
// compares them whenever the scheduler raises tx_req.
// ---------------------------------------------------------------------------
module tb_eth_tx_tick_scheduler;

    localparam int NUM_CH  = 4;
    localparam int INTV_W  = 16;
    localparam int CH_W    = 2;
    localparam int TO_10US = 100;

    logic                      clk = 1'b0;
    logic                      rstn;
    logic                      tick_10us;
    logic                      tick_1s;
    logic [NUM_CH-1:0]         cfg_en;
    logic [NUM_CH-1:0]         cfg_unit;
    logic [NUM_CH*INTV_W-1:0]  cfg_intv;
    logic                      busy;
    logic [NUM_CH-1:0]         pend;
    logic [NUM_CH-1:0]         ovf_flag;
    logic [NUM_CH-1:0]         ovf_clr;
    logic                      err_timeout;

    eth_tx_tick_scheduler_if #(.CH_W(CH_W)) bus ();

    eth_tx_tick_scheduler #(
        .NUM_CH (NUM_CH),
        .INTV_W (INTV_W),
        .CH_W   (CH_W),
        .TO_10US(TO_10US)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .tick_10us  (tick_10us),
        .tick_1s    (tick_1s),
        .cfg_en     (cfg_en),
        .cfg_unit   (cfg_unit),
        .cfg_intv   (cfg_intv),
        .tx         (bus),
        .busy       (busy),
        .pend       (pend),
        .ovf_flag   (ovf_flag),
        .ovf_clr    (ovf_clr),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    // responder knobs
    bit respond     = 1'b0;
    bit hold_done   = 1'b0;
    bit chk_ack_clr = 1'b1;
    bit resp_busy   = 1'b0;
    int ack_dly     = 0;
    int done_dly    = 0;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick10();
        @(negedge clk) tick_10us = 1'b1;
        @(negedge clk) tick_10us = 1'b0;
    endtask

    task automatic tick1s_pulse();
        @(negedge clk) tick_1s = 1'b1;
        @(negedge clk) tick_1s = 1'b0;
    endtask

    // Drop every enable for a couple of cycles so the new config reloads.
    task automatic cfg_set(input logic [3:0] en, input logic [3:0] unit,
                           input logic [63:0] intv);
        @(negedge clk) cfg_en = '0;
        repeat (2) @(negedge clk);
        cfg_unit = unit;
        cfg_intv = intv;
        cfg_en   = en;
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 500; w++) begin
            @(negedge clk);
            if (!busy && !resp_busy && exp_q.size() == 0) break;
        end
        chk_eq("idle_busy", int'(busy), 0);
        chk_eq("sb_drained", exp_q.size(), 0);
    endtask

    // TX-path model: compare channel, ack after ack_dly, done after done_dly.
    initial begin : responder
        int  ch;
        bit  done_with_ack;
        bus.tx_ack  = 1'b0;
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn && respond && bus.tx_req) begin
                resp_busy = 1'b1;
                chk_eq("sb_nonempty", int'(exp_q.size() > 0), 1);
                ch = -1;
                if (exp_q.size() > 0) ch = exp_q.pop_front();
                chk_eq("grant_ch", int'(bus.tx_ch), ch);
                $display("grant: tx_ch=%0d expected=%0d t=%0t", bus.tx_ch, ch, $time);
                repeat (ack_dly) @(negedge clk);
                bus.tx_ack    = 1'b1;
                done_with_ack = (done_dly == 0) && !hold_done;
                bus.tx_done   = done_with_ack;
                @(negedge clk);
                bus.tx_ack  = 1'b0;
                bus.tx_done = 1'b0;
                chk_eq("req_drop_on_ack", int'(bus.tx_req), 0);
                if (chk_ack_clr && ch >= 0)
                    chk_eq("pend_clr_on_ack", int'(pend[ch[1:0]]), 0);
                if (!done_with_ack) begin
                    repeat (done_dly) @(negedge clk);
                    for (int w = 0; w < 5000 && hold_done; w++) @(negedge clk);
                    if (hold_done) chk_eq("done_hold_bound", int'(hold_done), 0);
                    bus.tx_done = 1'b1;
                    @(negedge clk);
                    bus.tx_done = 1'b0;
                end
                resp_busy = 1'b0;
            end
        end
    end

    initial begin : main
        rstn      = 1'b0;
        tick_10us = 1'b0;
        tick_1s   = 1'b0;
        cfg_en    = '0;
        cfg_unit  = '0;
        cfg_intv  = '0;
        ovf_clr   = '0;

        // ---------------- reset state ----------------
        #3;
        chk_eq("rst_tx_req", int'(bus.tx_req), 0);
        chk_eq("rst_tx_ch", int'(bus.tx_ch), 0);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_pend", int'(pend), 0);
        chk_eq("rst_ovf", int'(ovf_flag), 0);
        chk_eq("rst_err_to", int'(err_timeout), 0);
        repeat (3) @(negedge clk);
        rstn    = 1'b1;
        respond = 1'b1;

        // ---------------- round robin, all intv=1 on 1 s ticks ----------------
        ack_dly = 0; done_dly = 0;
        cfg_set(4'b1111, 4'b1111, {16'd1, 16'd1, 16'd1, 16'd1});
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NUM_CH; c++) exp_q.push_back(c);
            tick1s_pulse();
            wait_idle();
            chk_eq("rr_no_ovf", int'(ovf_flag), 0);
        end

        // ---------------- ch0 intv=3 on 10 us ticks ----------------
        ack_dly = 2; done_dly = 10;
        cfg_set(4'b0001, 4'b0000, {16'd0, 16'd0, 16'd0, 16'd3});
        for (int p = 0; p < 3; p++) begin
            for (int t = 0; t < 2; t++) begin
                tick10();
                chk_eq("t1_no_pend", int'(pend), 0);
                chk_eq("t1_no_req", int'(bus.tx_req), 0);
            end
            exp_q.push_back(0);
            tick10();
            chk_eq("t1_pend_T1", int'(pend), 1);
            chk_eq("t1_req_T1", int'(bus.tx_req), 0);
            @(negedge clk);
            chk_eq("t1_req_T2", int'(bus.tx_req), 1);
            wait_idle();
        end

        // ---------------- overflow while grant stalled ----------------
        ack_dly = 0; done_dly = 0; hold_done = 1'b1;
        cfg_set(4'b0010, 4'b0000, {16'd0, 16'd0, 16'd1, 16'd0});
        exp_q.push_back(1);
        tick10();
        repeat (4) @(negedge clk);
        chk_eq("ovf_in_wait", int'(busy), 1);
        tick10();
        tick10();
        // set and clear of ovf in the same cycle: set wins
        @(negedge clk) begin tick_10us = 1'b1; ovf_clr = 4'b0010; end
        @(negedge clk) begin tick_10us = 1'b0; ovf_clr = 4'b0000; end
        chk_eq("ovf_pend1", int'(pend[1]), 1);
        chk_eq("ovf_flag1", int'(ovf_flag[1]), 1);
        exp_q.push_back(1);
        hold_done = 1'b0;
        wait_idle();
        chk_eq("ovf_pend1_served", int'(pend[1]), 0);
        @(negedge clk) ovf_clr = 4'b0010;
        @(negedge clk) ovf_clr = 4'b0000;
        chk_eq("ovf_cleared", int'(ovf_flag), 0);

        // ---------------- grant timeout ----------------
        respond = 1'b0;
        cfg_set(4'b1001, 4'b1001, {16'd2, 16'd0, 16'd0, 16'd1});
        tick1s_pulse();
        chk_eq("to_pend", int'(pend), 1);
        @(negedge clk);
        chk_eq("to_req", int'(bus.tx_req), 1);
        chk_eq("to_req_ch", int'(bus.tx_ch), 0);
        for (int t = 0; t < TO_10US - 1; t++) tick10();
        chk_eq("to_busy_before", int'(busy), 1);
        chk_eq("to_err_before", int'(err_timeout), 0);
        tick10();
        chk_eq("to_err_pulse", int'(err_timeout), 1);
        chk_eq("to_busy_after", int'(busy), 0);
        chk_eq("to_pend_clr", int'(pend), 0);
        @(negedge clk);
        chk_eq("to_err_one_cycle", int'(err_timeout), 0);
        respond = 1'b1;
        // rr now points at ch0, so ch3 is searched first
        exp_q.push_back(3);
        exp_q.push_back(0);
        tick1s_pulse();
        wait_idle();

        // ---------------- zero interval / disable mid-grant ----------------
        cfg_set(4'b0100, 4'b0000, 64'd0);
        for (int t = 0; t < 3; t++) tick10();
        chk_eq("intv0_no_pend", int'(pend), 0);
        chk_eq("intv0_idle", int'(busy), 0);
        @(negedge clk) cfg_intv = {16'd0, 16'd1, 16'd0, 16'd0};
        hold_done = 1'b1;
        exp_q.push_back(2);
        tick10();
        repeat (4) @(negedge clk);
        chk_eq("dis_in_wait", int'(busy), 1);
        @(negedge clk) cfg_en = 4'b0000;
        tick10();
        chk_eq("dis_pend2", int'(pend[2]), 0);
        chk_eq("dis_still_busy", int'(busy), 1);
        hold_done = 1'b0;
        wait_idle();
        chk_eq("dis_pend_final", int'(pend), 0);

        // ---------------- async reset mid-request ----------------
        respond = 1'b0;
        cfg_set(4'b0001, 4'b0000, {16'd0, 16'd0, 16'd0, 16'd1});
        tick10();
        @(negedge clk);
        chk_eq("ar_req", int'(bus.tx_req), 1);
        tick10();
        chk_eq("ar_ovf_before", int'(ovf_flag[0]), 1);
        #2 rstn = 1'b0;
        #1;
        chk_eq("ar_req_drop", int'(bus.tx_req), 0);
        chk_eq("ar_pend", int'(pend), 0);
        chk_eq("ar_ovf", int'(ovf_flag), 0);
        chk_eq("ar_busy", int'(busy), 0);
        cfg_intv = {16'd0, 16'd0, 16'd0, 16'd2};
        @(negedge clk) rstn = 1'b1;
        respond = 1'b1;
        tick10();
        chk_eq("ar_tick1_pend", int'(pend), 0);
        @(negedge clk);
        chk_eq("ar_tick1_req", int'(bus.tx_req), 0);
        exp_q.push_back(0);
        tick10();
        chk_eq("ar_tick2_pend", int'(pend[0]), 1);
        @(negedge clk);
        chk_eq("ar_tick2_req", int'(bus.tx_req), 1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
